ann_mac_layer: RTL and testbench
================================

// Module: ann_mac_layer
// PURPOSE
//   Parametrised fully-connected ANN layer with N_OUT neurons over N_IN signed inputs.
//   A single time-multiplexed MAC does the arithmetic, followed by ReLU, requantise and saturate.
//   Weights load serially through a config byte stream. Input and output vectors stream through valid/ready.
//   Sits behind the tt_um_sbasu3 pin mux; it is the generalised successor of the fixed single-neuron datapath.
// PARAMETERS
//   DATA_W  8  width of inputs, weights and outputs (signed two's complement; outputs are non-negative after ReLU)
//   N_IN    4  inputs per neuron (>=2)
//   N_OUT   4  neurons in the layer (>=1)
//   SHIFT   4  arithmetic right shift applied to the accumulator before saturation (Q-format of weights)
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   ena        in   1       design enable; 0 = full stall
//   cfg_we     in   1       config write strobe
//   cfg_data   in   DATA_W  weight (or bias) byte
//   in_valid   in   1       input sample valid
//   in_data    in   DATA_W  input sample, element order i=0..N_IN-1
//   in_ready   out  1       layer accepts an input sample
//   out_valid  out  1       neuron result valid
//   out_data   out  DATA_W  neuron result, order j=0..N_OUT-1
//   out_ready  in   1       downstream accepts the result
//   busy       out  1       high in S_MAC or S_EMIT
// BEHAVIOUR
//   Reset values:
//     - outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
//     - internal state: state=S_IN, all counters=0, weight regs=0, input buffer=0, accumulator=0.
//   FSM states:
//     - S_IN: in_ready=1. Each in_valid&in_ready stores in_data into buf[in_cnt] and increments in_cnt.
//       Accepting element N_IN-1 moves to S_MAC with neuron j=0 and the accumulator cleared.
//     - S_MAC: N_IN cycles, k=0..N_IN-1, each doing acc += buf[k]*w[j][k] (full-precision signed).
//       The cycle after k=N_IN-1 enters S_EMIT.
//     - S_EMIT: out_valid=1. out_data=sat(max(acc,0)>>>SHIFT, 0..2^(DATA_W-1)-1), registered on entry.
//       out_data and out_valid hold stable until out_valid&out_ready.
//       On handshake with j<N_OUT-1: j++, clear acc, go to S_MAC next cycle.
//       On handshake with j==N_OUT-1: go to S_IN, and in_ready=1 the next cycle.
//   Latency:
//     - last input accepted -> first out_valid: N_IN+1 cycles.
//     - output handshake -> next out_valid: N_IN+1 cycles.
//   Accumulator width: ACC_W = 2*DATA_W + clog2(N_IN) + 1; it cannot overflow.
//   Config:
//     - cfg_we writes are accepted only in S_IN with in_cnt==0, and are silently dropped otherwise.
//     - Write pointer order: w[0][0..N_IN-1], w[1][..], ... It wraps to 0 after the last entry.
//   ena=0 is a full stall:
//     - in_ready is forced to 0, and in, out and cfg handshakes are not taken.
//     - FSM, counters and acc freeze; out_valid and out_data hold.
//   Simultaneous cfg_we and in_valid in S_IN with in_cnt==0: both are accepted (independent paths).
//   Reset mid-operation (any state): all state returns to reset values immediately. Weights are cleared too.
// CONFIGURATION
//   ANN_BIAS_EN defined:
//     - Config stream carries N_IN*N_OUT weights followed by N_OUT bias bytes b[j]; the pointer wraps after the last bias.
//     - The accumulator is preset to sign_extend(b[j])<<SHIFT when neuron j starts (both the S_IN->S_MAC entry and every S_EMIT->S_MAC).
//   ANN_BIAS_EN undefined:
//     - No bias storage; the accumulator is preset to 0.
//     - The pointer wraps after N_IN*N_OUT entries.
// STRUCTURE
//   ann_pkg holds:
//     - state enum {S_IN, S_MAC, S_EMIT};
//     - function acc_width(DATA_W, N_IN);
//     - function relu_sat(acc, SHIFT, DATA_W).
//   Sub-module ann_mac holds the signed DATA_W x DATA_W multiply plus ACC_W accumulator, with ports clr/preset/en.
//   Weight regs, input buffer and FSM stay in ann_mac_layer.
// TESTING (DATA_W=8, N_IN=4, N_OUT=4, SHIFT=4)
//   1. Reset -> in_ready=1, out_valid=0, out_data=0, busy=0. Pulse rst_n low mid-S_MAC -> same values next edge, weights read back 0.
//   2. Weights w[j][i]=16 if i==j else 0; inputs 10,20,30,40 -> outputs 10,20,30,40 in order.
//      First out_valid comes 5 cycles after the last input handshake.
//   3. All weights -16; inputs 1,2,3,4 -> acc=-160 -> all four outputs 0 (ReLU).
//   4. All weights 127; inputs 127 x4 -> acc=64516, >>>4=4032 -> all outputs saturate to 127.
//   5. Hold out_ready=0 for 5 cycles on neuron 1 -> out_valid=1 with out_data stable; no in_ready.
//      Also drop ena for 3 cycles mid-S_MAC -> results are unchanged, timing extended by 3 cycles.
//   6. cfg_we pulses during S_MAC are dropped (results match test 2).
//      With ANN_BIAS_EN: zero weights and b[j]=5 -> all outputs 5.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared types and helpers for the fully-connected ANN layer:
// FSM state encoding, accumulator sizing, and the ReLU/requantise/saturate step.
package ann_pkg;

    typedef enum logic [1:0] {
        S_IN   = 2'd0,
        S_MAC  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    // Product width plus growth for summing n_in terms plus one extra sign bit,
    // so the accumulator cannot overflow even with a bias preset.
    function automatic int acc_width(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in) + 1;
    endfunction

    // ReLU, arithmetic right shift, then clamp to the positive DATA_W range.
    function automatic longint relu_sat(input longint acc, input int shift, input int data_w);
        longint s;
        longint mx;
        mx = (longint'(1) <<< (data_w - 1)) - 1;
        if (acc <= 0) return 0;
        s = acc >>> shift;
        if (s > mx) return mx;
        return s;
    endfunction

endpackage

// File: rtl/ann_mac.sv
// Signed multiply-accumulate used by the layer: clr loads the preset value
// (zero or a scaled bias), en adds one a*b product.
module ann_mac
    import ann_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic signed [ACC_W-1:0]  preset,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;

    // Full-precision product and next accumulator value (clear has priority).
    always_comb begin
        prod  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        acc_d = acc_q;
        if (clr) begin
            acc_d = preset;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ann_mac_layer.sv
// Fully-connected ANN layer: N_OUT neurons over N_IN signed inputs, one shared
// MAC, then ReLU / shift / saturate. Weights arrive on a serial config stream.
// Optional feature macro: ANN_BIAS_EN adds N_OUT bias bytes after the weights
// and presets the accumulator with each neuron's scaled bias.
module ann_mac_layer
    import ann_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_we,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    localparam int ACC_W = acc_width(DATA_W, N_IN);
    localparam int N_WT  = N_IN * N_OUT;
`ifdef ANN_BIAS_EN
    localparam int N_CFG = N_WT + N_OUT;
`else
    localparam int N_CFG = N_WT;
`endif
    localparam int IN_W  = $clog2(N_IN);
    localparam int K_W   = $clog2(N_IN + 1);
    localparam int J_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int PTR_W = $clog2(N_CFG);

    state_t                    state_q, state_d;
    logic [IN_W-1:0]           in_cnt_q, in_cnt_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [J_W-1:0]            j_q, j_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic signed [DATA_W-1:0]  buf_q [N_IN];
    logic signed [DATA_W-1:0]  buf_d [N_IN];
    logic signed [DATA_W-1:0]  w_q [N_WT];
    logic signed [DATA_W-1:0]  w_d [N_WT];

    logic                      cfg_take;
    logic [IN_W-1:0]           k_sel;
    logic                      mac_clr;
    logic                      mac_en;
    logic signed [ACC_W-1:0]   mac_preset;
    logic signed [DATA_W-1:0]  mac_a;
    logic signed [DATA_W-1:0]  mac_b;
    logic signed [ACC_W-1:0]   mac_acc;

    assign in_ready  = ena && (state_q == S_IN);
    assign busy      = (state_q != S_IN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Config bytes are only taken while no input vector is partially loaded.
    assign cfg_take = ena && cfg_we && (state_q == S_IN) && (in_cnt_q == '0);

    // Operand select; k_sel parks at 0 on the drain cycle so indices stay in range.
    always_comb begin
        k_sel = (k_q < K_W'(N_IN)) ? k_q[IN_W-1:0] : '0;
        mac_a = buf_q[k_sel];
        mac_b = w_q[int'(j_q) * N_IN + int'(k_sel)];
    end

`ifdef ANN_BIAS_EN
    logic signed [DATA_W-1:0] b_q [N_OUT];
    logic signed [DATA_W-1:0] b_d [N_OUT];
    logic [J_W-1:0]           preset_j;

    // Preset for the neuron about to start: j=0 from S_IN, j+1 from S_EMIT.
    always_comb begin
        preset_j = '0;
        if (state_q == S_EMIT && j_q != J_W'(N_OUT - 1)) begin
            preset_j = j_q + J_W'(1);
        end
        mac_preset = ACC_W'(b_q[preset_j]) <<< SHIFT;
    end

    // Serial config writer: weights first, then biases, pointer wraps after the last bias.
    always_comb begin
        w_d   = w_q;
        b_d   = b_q;
        ptr_d = ptr_q;
        if (cfg_take) begin
            if (int'(ptr_q) < N_WT) begin
                w_d[int'(ptr_q)] = cfg_data;
            end else begin
                b_d[int'(ptr_q) - N_WT] = cfg_data;
            end
            ptr_d = (ptr_q == PTR_W'(N_CFG - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Bias registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) b_q[i] <= '0;
        end else begin
            b_q <= b_d;
        end
    end
`else
    assign mac_preset = '0;

    // Serial config writer: weights only, pointer wraps after the last weight.
    always_comb begin
        w_d   = w_q;
        ptr_d = ptr_q;
        if (cfg_take) begin
            w_d[int'(ptr_q)] = cfg_data;
            ptr_d = (ptr_q == PTR_W'(N_CFG - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end
`endif

    // FSM next state: gather inputs, run N_IN MACs plus a drain cycle, emit per neuron.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        k_d         = k_q;
        j_d         = j_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        if (ena) begin
            case (state_q)
                S_IN: begin
                    if (in_valid) begin
                        buf_d[in_cnt_q] = in_data;
                        if (in_cnt_q == IN_W'(N_IN - 1)) begin
                            in_cnt_d = '0;
                            state_d  = S_MAC;
                            j_d      = '0;
                            k_d      = '0;
                            mac_clr  = 1'b1;
                        end else begin
                            in_cnt_d = in_cnt_q + IN_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    if (k_q < K_W'(N_IN)) begin
                        mac_en = 1'b1;
                        k_d    = k_q + K_W'(1);
                    end else begin
                        k_d         = '0;
                        state_d     = S_EMIT;
                        out_valid_d = 1'b1;
                        out_data_d  = DATA_W'(relu_sat(longint'(mac_acc), SHIFT, DATA_W));
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (j_q == J_W'(N_OUT - 1)) begin
                            j_d     = '0;
                            state_d = S_IN;
                        end else begin
                            j_d     = j_q + J_W'(1);
                            state_d = S_MAC;
                            mac_clr = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IN;
                end
            endcase
        end
    end

    // Control, buffer and weight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IN;
            in_cnt_q    <= '0;
            k_q         <= '0;
            j_q         <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < N_IN; i++) buf_q[i] <= '0;
            for (int i = 0; i < N_WT; i++) w_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            k_q         <= k_d;
            j_q         <= j_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            buf_q       <= buf_d;
            w_q         <= w_d;
        end
    end

    ann_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mac_clr),
        .preset (mac_preset),
        .en     (mac_en),
        .a      (mac_a),
        .b      (mac_b),
        .acc    (mac_acc)
    );

endmodule

// File: tb/tb_ann_mac_layer.sv
// Directed testbench for ann_mac_layer (DATA_W=8, N_IN=4, N_OUT=4, SHIFT=4).
// Bias stimulus is included when ANN_BIAS_EN is defined.
module tb_ann_mac_layer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_data = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] wtab [16];
    logic [7:0] btab [4];
    logic [7:0] ins  [4];
    logic [7:0] exps [4];

    ann_mac_layer #(.DATA_W(8), .N_IN(4), .N_OUT(4), .SHIFT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cfg_we    (cfg_we),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] v);
        cfg_we   = 1'b1;
        cfg_data = v;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic load_cfg();
        for (int i = 0; i < 16; i++) cfg_write(wtab[i]);
`ifdef ANN_BIAS_EN
        for (int i = 0; i < 4; i++) cfg_write(btab[i]);
`endif
    endtask

    task automatic set_weights_identity();
        for (int i = 0; i < 16; i++) wtab[i] = ((i / 4) == (i % 4)) ? 8'd16 : 8'd0;
    endtask

    task automatic set_weights_all(input logic [7:0] v);
        for (int i = 0; i < 16; i++) wtab[i] = v;
    endtask

    task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        ins[0] = a; ins[1] = b; ins[2] = c; ins[3] = d;
    endtask

    task automatic set_exps(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        exps[0] = a; exps[1] = b; exps[2] = c; exps[3] = d;
    endtask

    task automatic send_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = ins[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic collect_from(input string tag, input int first);
        int c;
        for (int j = first; j < 4; j++) begin
            wait_valid(c);
            check($sformatf("%s_valid%0d", tag, j), out_valid, 1);
            check($sformatf("%s_data%0d", tag, j), out_data, exps[j]);
            handshake();
        end
        check($sformatf("%s_in_ready_after", tag), in_ready, 1);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 4; i++) btab[i] = 8'd0;

        // Reset values
        ena = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Identity weights, latency from last input and between outputs
        set_weights_identity();
        load_cfg();
        set_inputs(8'd10, 8'd20, 8'd30, 8'd40);
        set_exps(8'd10, 8'd20, 8'd30, 8'd40);
        send_inputs();
        check("id_busy", busy, 1);
        wait_valid(c);
        check("id_first_latency", c, 5);
        check("id_data0", out_data, 10);
        handshake();
        wait_valid(c);
        check("id_next_latency", c, 5);
        collect_from("id", 1);

        // All weights -16: negative accumulator clipped by ReLU
        set_weights_all(8'hF0);
        load_cfg();
        set_inputs(8'd1, 8'd2, 8'd3, 8'd4);
        set_exps(8'd0, 8'd0, 8'd0, 8'd0);
        send_inputs();
        collect_from("relu", 0);

        // All weights 127, inputs 127: saturate at 127
        set_weights_all(8'd127);
        load_cfg();
        set_inputs(8'd127, 8'd127, 8'd127, 8'd127);
        set_exps(8'd127, 8'd127, 8'd127, 8'd127);
        send_inputs();
        collect_from("sat", 0);

        // All weights 1: acc=100, shift by 4 truncates to 6
        set_weights_all(8'd1);
        load_cfg();
        set_inputs(8'd10, 8'd20, 8'd30, 8'd40);
        set_exps(8'd6, 8'd6, 8'd6, 8'd6);
        send_inputs();
        collect_from("shift", 0);

        // Backpressure on neuron 1
        set_weights_identity();
        load_cfg();
        set_inputs(8'd10, 8'd20, 8'd30, 8'd40);
        set_exps(8'd10, 8'd20, 8'd30, 8'd40);
        send_inputs();
        wait_valid(c);
        check("bp_data0", out_data, 10);
        handshake();
        wait_valid(c);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
            check($sformatf("bp_hold_data%0d", i), out_data, 20);
            check($sformatf("bp_hold_in_ready%0d", i), in_ready, 0);
        end
        collect_from("bp", 1);

        // ena low in S_IN: no in_ready, input not taken
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd99;
        #1;
        check("stall_in_ready", in_ready, 0);
        tick();
        tick();
        in_valid = 1'b0;
        ena      = 1'b1;

        // ena low for 3 cycles mid-S_MAC: timing stretches by 3, results unchanged
        send_inputs();
        tick();
        tick();
        ena = 1'b0;
        tick();
        tick();
        tick();
        check("stall_out_valid", out_valid, 0);
        ena = 1'b1;
        wait_valid(c);
        check("stall_latency", c + 5, 8);
        collect_from("stall", 0);

        // cfg_we during S_MAC is dropped
        send_inputs();
        cfg_we   = 1'b1;
        cfg_data = 8'h7F;
        tick();
        tick();
        tick();
        cfg_we   = 1'b0;
        collect_from("cfgdrop", 0);
        // Pointer must still be at 0: a fresh load of all-1 weights gives 6s
        set_weights_all(8'd1);
        load_cfg();
        set_exps(8'd6, 8'd6, 8'd6, 8'd6);
        send_inputs();
        collect_from("cfgptr", 0);

`ifdef ANN_BIAS_EN
        // Zero weights, bias 5 on every neuron
        set_weights_all(8'd0);
        for (int i = 0; i < 4; i++) btab[i] = 8'd5;
        load_cfg();
        set_exps(8'd5, 8'd5, 8'd5, 8'd5);
        send_inputs();
        collect_from("bias", 0);
        for (int i = 0; i < 4; i++) btab[i] = 8'd0;
`endif

        // Reset mid-S_MAC clears state and weights
        set_weights_identity();
        load_cfg();
        send_inputs();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        tick();
        check("midrst_edge_busy", busy, 0);
        check("midrst_edge_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();
        set_exps(8'd0, 8'd0, 8'd0, 8'd0);
        send_inputs();
        collect_from("midrst_weights", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
